// File: rtl/vcfg_ctx_unit.sv
// Multi-context vector configuration unit: decodes vsetvl* requests, computes vl = min(AVL, VLMAX)
// and holds per-context vtype/vl/vstart, with a single registered response stage.
module vcfg_ctx_unit #(
    parameter int VLEN  = 4096,
    parameter int ELEN  = 64,
    parameter int NrCtx = 4,
    parameter int XLEN  = 64,
    localparam int VlW  = $clog2(VLEN) + 1,
    localparam int CtxW = (NrCtx > 1) ? $clog2(NrCtx) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [CtxW-1:0]                req_ctx_i,
    input  logic [XLEN-1:0]                req_avl_i,
    input  logic [XLEN-1:0]                req_vtype_i,
    input  logic                           req_rs1_x0_i,
    input  logic                           req_rd_x0_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [VlW-1:0]                 rsp_vl_o,
    output logic [CtxW-1:0]                rsp_ctx_o,
    output logic                           rsp_vill_o,
    input  logic [NrCtx-1:0]               ctx_clear_i,
    output logic [NrCtx-1:0][XLEN-1:0]     vtype_o,
    output logic [NrCtx-1:0][VlW-1:0]      vl_o,
    output logic [NrCtx-1:0][VlW-1:0]      vstart_o
);

    localparam logic [2:0]      VlutCbseq = 3'b000;
    localparam logic [XLEN-1:0] VtypeIll  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [VlW+2:0]  VlenBytes = (VlW+3)'(VLEN / 8);

    function automatic logic vtype_illegal(input logic [XLEN-1:0] vt);
        logic [2:0] vlmul;
        logic [2:0] vsew;
        logic [2:0] vlut;
        int         sew;
        logic       ill;
        vlmul = vt[2:0];
        vsew  = vt[5:3];
        vlut  = vt[10:8];
        sew   = 8 << vsew;
        ill   = 1'b0;
        if (vt[XLEN-1] || (|vt[XLEN-2:12])) ill = 1'b1;
        if (vlmul == 3'b100) ill = 1'b1;
        if (vsew[2] || (sew > ELEN)) ill = 1'b1;
        // Fractional LMUL: SEW must not exceed ELEN*LMUL.
        if (vlmul[2] && (vlmul != 3'b100) && (sew > (ELEN >> (8 - int'(vlmul))))) ill = 1'b1;
        if (vt[11] && (vlut == VlutCbseq)) ill = 1'b1;
        if ((vlut != VlutCbseq) && (sew > 16)) ill = 1'b1;
        return ill;
    endfunction

    function automatic logic [VlW-1:0] calc_vlmax(input logic [2:0] vsew, input logic [2:0] vlmul);
        logic [VlW+2:0] vlmax;
        vlmax = VlenBytes >> vsew;
        if (vlmul[2]) vlmax = vlmax >> (4'd8 - {1'b0, vlmul});
        else          vlmax = vlmax << vlmul;
        return vlmax[VlW-1:0];
    endfunction

    logic [NrCtx-1:0][XLEN-1:0] vtype_q;
    logic [NrCtx-1:0][VlW-1:0]  vl_q;
    logic [NrCtx-1:0][VlW-1:0]  vstart_q;
    logic [NrCtx-1:0][VlW-1:0]  vlmax_q;

    logic            vld_p1;
    logic [VlW-1:0]  rsp_vl_p1;
    logic [CtxW-1:0] rsp_ctx_p1;
    logic            rsp_vill_p1;

    logic            accept;
    logic [VlW-1:0]  cur_vl;
    logic [VlW-1:0]  cur_vlmax;
    logic [VlW-1:0]  new_vlmax;
    logic [VlW-1:0]  new_vl;
    logic            new_ill;

    assign req_ready_o = !vld_p1 || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        cur_vl    = '0;
        cur_vlmax = '0;
        for (int k = 0; k < NrCtx; k++) begin
            if (req_ctx_i == CtxW'(k)) begin
                cur_vl    = vl_q[k];
                cur_vlmax = vlmax_q[k];
            end
        end
        new_vlmax = calc_vlmax(req_vtype_i[5:3], req_vtype_i[2:0]);
        new_ill   = vtype_illegal(req_vtype_i);
        new_vl    = new_vlmax;
        if (!req_rs1_x0_i) begin
            // Full-width compare so large AVLs saturate instead of wrapping.
            if (req_avl_i < {{(XLEN-VlW){1'b0}}, new_vlmax}) new_vl = req_avl_i[VlW-1:0];
        end else if (req_rd_x0_i) begin
            new_vl = cur_vl;
            if (new_vlmax != cur_vlmax) new_ill = 1'b1;
        end
        if (new_ill) new_vl = '0;
    end

    // Stage p0 -> p1: response register and context commit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1      <= 1'b0;
            rsp_vl_p1   <= '0;
            rsp_ctx_p1  <= '0;
            rsp_vill_p1 <= 1'b0;
            for (int k = 0; k < NrCtx; k++) begin
                vtype_q[k]  <= VtypeIll;
                vl_q[k]     <= '0;
                vstart_q[k] <= '0;
                vlmax_q[k]  <= '0;
            end
        end else begin
            if (accept) begin
                vld_p1      <= 1'b1;
                rsp_vl_p1   <= new_vl;
                rsp_ctx_p1  <= req_ctx_i;
                rsp_vill_p1 <= new_ill;
            end else if (rsp_ready_i) begin
                vld_p1 <= 1'b0;
            end
            for (int k = 0; k < NrCtx; k++) begin
                if (ctx_clear_i[k]) begin
                    vtype_q[k]  <= VtypeIll;
                    vl_q[k]     <= '0;
                    vstart_q[k] <= '0;
                    vlmax_q[k]  <= '0;
                end else if (accept && (req_ctx_i == CtxW'(k))) begin
                    vtype_q[k]  <= new_ill ? VtypeIll : {1'b0, req_vtype_i[XLEN-2:0]};
                    vl_q[k]     <= new_vl;
                    vstart_q[k] <= '0;
                    vlmax_q[k]  <= new_ill ? '0 : new_vlmax;
                end
            end
        end
    end

    assign rsp_valid_o = vld_p1;
    assign rsp_vl_o    = rsp_vl_p1;
    assign rsp_ctx_o   = rsp_ctx_p1;
    assign rsp_vill_o  = rsp_vill_p1;
    assign vtype_o     = vtype_q;
    assign vl_o        = vl_q;
    assign vstart_o    = vstart_q;

endmodule
